fp16_seq_div: RTL and testbench

Iterative half-precision (1/5/10, bias 15) floating-point divider with a valid/ready handshake on both sides. It is the inverse-operation partner of the pipelined FP16 multiplier in the same datapath and uses the same operand encoding and 5-bit flag vector. It computes one quotient per transaction with a restoring mantissa divider, one bit per cycle, and its latency is fixed.

---
 rtl/fp16_pkg.sv | 39 +++
 rtl/fp16_div_mant_core.sv | 73 +++++++
 rtl/fp16_seq_div.sv | 207 ++++++++++++++++++++
 tb/tb_fp16_seq_div.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 encoding constants, flag indices and divider FSM states.
// Used by the iterative divider and its mantissa core.
package fp16_pkg;

    localparam int SIGN_POS = 15;
    localparam int EXP_HI   = 14;
    localparam int EXP_LO   = 10;
    localparam int MANT_HI  = 9;
    localparam int MANT_LO  = 0;
    localparam int EXP_W    = EXP_HI - EXP_LO + 1;
    localparam int MANT_W   = MANT_HI - MANT_LO + 1;

    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_ROUND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp16_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per cycle after a start pulse.
// Latency ITER cycles after start; done marks the final iteration cycle.
// No backpressure: runs to completion once started, a new start restarts it.
module fp16_div_mant_core
    import fp16_pkg::*;
#(
    parameter int ITER = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W:0]   ma,
    input  logic [MANT_W:0]   mb,
    output logic              done,
    output logic [ITER-1:0]   q,
    output logic              rem_nz
);

    localparam int CNT_W = $clog2(ITER);

    logic [MANT_W+1:0] r_q, r_d, r_sub;
    logic [MANT_W:0]   mb_q, mb_d;
    logic [ITER-1:0]   q_q, q_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              ge;

    always_comb begin
        r_d   = r_q;
        mb_d  = mb_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        run_d = run_q;
        ge    = (r_q >= {1'b0, mb_q});
        r_sub = r_q - {1'b0, mb_q};
        if (start) begin
            r_d   = {1'b0, ma};
            mb_d  = mb;
            q_d   = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            // Partial remainder stays below 2*Mb, so 12 bits never overflow.
            r_d   = (ge ? r_sub : r_q) << 1;
            q_d   = {q_q[ITER-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            mb_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            mb_q  <= mb_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done   = run_q && (cnt_q == CNT_W'(ITER - 1));
    assign q      = q_q;
    assign rem_nz = (r_q != '0);

endmodule

// File: rtl/fp16_seq_div.sv
// Iterative FP16 divider; round-to-nearest-even with FP16_DIV_RNE_EN, else truncate.
// Latency: out_valid 16 cycles after the accept cycle, independent of operands.
// Backpressure: single transaction in flight; in_ready low until result is taken.
module fp16_seq_div
    import fp16_pkg::*;
#(
    parameter int ITER = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [4:0]  flags
);

    localparam logic signed [6:0] EE_MAX  = 7'(EXP_MAX);
    localparam logic signed [6:0] EE_BIAS = 7'(BIAS);

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [6:0]  ee_q, ee_d;
    logic               sp_q, sp_d;
    logic [15:0]        sp_res_q, sp_res_d;
    logic [4:0]         sp_flg_q, sp_flg_d;
    logic [15:0]        result_q, result_d;
    logic [4:0]         flags_q, flags_d;

    fp16_t              fa, fb;
    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic               sp_hit, sign_c;
    logic [15:0]        sp_res;
    logic [4:0]         sp_flg;

    logic               core_done, core_rem_nz;
    logic [ITER-1:0]    core_q;

    logic [MANT_W-1:0]  mant;
    logic               guard, sticky;
    logic signed [6:0]  e_adj;
    logic [15:0]        rnd_res;
    logic [4:0]         rnd_flg;
`ifdef FP16_DIV_RNE_EN
    logic [MANT_W:0]    mant_inc;
`endif

    always_comb begin
        fa     = fp16_t'(a_q);
        fb     = fp16_t'(b_q);
        a_zero = (fa.exp == '0);
        b_zero = (fb.exp == '0);
        a_inf  = (fa.exp == '1) && (fa.frac == '0);
        b_inf  = (fb.exp == '1) && (fb.frac == '0);
        a_nan  = (fa.exp == '1) && (fa.frac != '0);
        b_nan  = (fb.exp == '1) && (fb.frac != '0);
        sign_c = fa.sign ^ fb.sign;
        sp_hit = 1'b1;
        sp_res = '0;
        sp_flg = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res         = QNAN;
            sp_flg[FLG_NV] = 1'b1;
        end else if (!a_inf && b_zero) begin
            sp_res         = PINF | {sign_c, 15'b0};
            sp_flg[FLG_DZ] = 1'b1;
        end else if (a_inf) begin
            sp_res = PINF | {sign_c, 15'b0};
        end else if (a_zero || b_inf) begin
            sp_res = {sign_c, 15'b0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    fp16_div_mant_core #(
        .ITER (ITER)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (state_q == ST_PREP),
        .ma     ({1'b1, fa.frac}),
        .mb     ({1'b1, fb.frac}),
        .done   (core_done),
        .q      (core_q),
        .rem_nz (core_rem_nz)
    );

    // Normalise the quotient (in [0.5, 2)) to 1.xxx, then round and range-check.
    always_comb begin
        if (core_q[12]) begin
            mant   = core_q[11:2];
            guard  = core_q[1];
            sticky = core_q[0] | core_rem_nz;
            e_adj  = ee_q;
        end else begin
            mant   = core_q[10:1];
            guard  = core_q[0];
            sticky = core_rem_nz;
            e_adj  = ee_q - 7'sd1;
        end
`ifdef FP16_DIV_RNE_EN
        mant_inc = {1'b0, mant} + {{MANT_W{1'b0}}, guard & (sticky | mant[0])};
        if (mant_inc[MANT_W]) begin
            e_adj = e_adj + 7'sd1;
            mant  = '0;
        end else begin
            mant = mant_inc[MANT_W-1:0];
        end
`endif
        rnd_flg = '0;
        if (e_adj >= EE_MAX) begin
            rnd_res         = PINF | {sign_q, 15'b0};
            rnd_flg[FLG_OF] = 1'b1;
            rnd_flg[FLG_NX] = 1'b1;
        end else if (e_adj <= 7'sd0) begin
            rnd_res         = {sign_q, 15'b0};
            rnd_flg[FLG_UF] = 1'b1;
            rnd_flg[FLG_NX] = 1'b1;
        end else begin
            rnd_res         = {sign_q, e_adj[EXP_W-1:0], mant};
            rnd_flg[FLG_NX] = guard | sticky;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        ee_d     = ee_q;
        sp_d     = sp_q;
        sp_res_d = sp_res_q;
        sp_flg_d = sp_flg_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                sign_d   = sign_c;
                ee_d     = signed'({2'b00, fa.exp}) - signed'({2'b00, fb.exp}) + EE_BIAS;
                sp_d     = sp_hit;
                sp_res_d = sp_res;
                sp_flg_d = sp_flg;
                state_d  = ST_DIV;
            end
            ST_DIV: begin
                if (core_done) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                result_d = sp_q ? sp_res_q : rnd_res;
                flags_d  = sp_q ? sp_flg_q : rnd_flg;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            ee_q     <= '0;
            sp_q     <= 1'b0;
            sp_res_q <= '0;
            sp_flg_q <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            ee_q     <= ee_d;
            sp_q     <= sp_d;
            sp_res_q <= sp_res_d;
            sp_flg_q <= sp_flg_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp16_seq_div.sv
// Scoreboard bench for fp16_seq_div: directed operands with hand-computed quotients.
module tb_fp16_seq_div;

    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  flg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [4:0]  flags;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    fp16_seq_div #(.ITER(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    task automatic wait_level(input logic want_valid, input string name);
        int w = 0;
        while ((out_valid !== want_valid) && (w < 40)) begin
            @(posedge clk); #1;
            w++;
        end
        if (out_valid !== want_valid) fail_now(name);
    endtask

    task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb,
                          input logic [15:0] er, input logic [4:0] ef);
        int t0;
        int w = 0;
        while (!in_ready && (w < 40)) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) fail_now("in_ready_wait");
        a = ta;
        b = tb;
        in_valid = 1'b1;
        t0 = cyc;
        exp_q.push_back('{res: er, flg: ef});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'(in_ready), 32'd0);
        wait_level(1'b1, "out_valid_rise");
        check("latency", 32'(cyc - t0), 32'd16);
        wait_level(1'b0, "out_valid_fall");
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h/%h with nothing expected", result, flags);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("flags", 32'(flags), 32'(e.flg));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] va [14] = '{16'h4000, 16'h3C00, 16'h3C00, 16'h0000, 16'hFC00, 16'h7BFF, 16'h0400,
                             16'h7E00, 16'h3C00, 16'hC000, 16'h7C00, 16'h7C00, 16'hBC00, 16'h3E00};
    logic [15:0] vb [14] = '{16'h3C00, 16'h4200, 16'h0000, 16'h0000, 16'h4000, 16'h3800, 16'h7800,
                             16'h3C00, 16'h7C00, 16'h3C00, 16'h0000, 16'h7C00, 16'h0000, 16'h4000};
    logic [15:0] vr [14] = '{16'h4000, 16'h3555, 16'h7C00, 16'h7E00, 16'hFC00, 16'h7C00, 16'h0000,
                             16'h7E00, 16'h0000, 16'hC000, 16'h7C00, 16'h7E00, 16'hFC00, 16'h3A00};
    logic [4:0]  vf [14] = '{5'h00, 5'h01, 5'h08, 5'h10, 5'h00, 5'h05, 5'h03,
                             5'h10, 5'h00, 5'h00, 5'h00, 5'h10, 5'h08, 5'h00};

    initial begin
        int t1;
        int spurious;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'h0000);
        check("rst_flags", 32'(flags), 32'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            do_txn(va[i], vb[i], vr[i], vf[i]);
        end

        // Backpressure: result held while a second request waits.
        out_ready = 1'b0;
        a = 16'h3C00;
        b = 16'h4200;
        in_valid = 1'b1;
        t1 = cyc;
        exp_q.push_back('{res: 16'h3555, flg: 5'h01});
        @(posedge clk); #1;
        a = 16'h4400;
        b = 16'h4000;
        wait_level(1'b1, "bp_out_valid_rise");
        check("bp_latency", 32'(cyc - t1), 32'd16);
        for (int i = 0; i < 10; i++) begin
            check("bp_result_stable", 32'(result), 32'h3555);
            check("bp_flags_stable", 32'(flags), 32'h01);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        exp_q.push_back('{res: 16'h4000, flg: 5'h00});
        @(posedge clk); #1;
        check("bp_idle_after_take", 32'(in_ready), 32'd1);
        check("bp_out_valid_drop", 32'(out_valid), 32'd0);
        t1 = cyc;
        @(posedge clk); #1;
        check("bp_second_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_level(1'b1, "bp2_out_valid_rise");
        check("bp2_latency", 32'(cyc - t1), 32'd16);
        wait_level(1'b0, "bp2_out_valid_fall");

        // Reset during the 5th DIV cycle discards the transaction.
        a = 16'h3C00;
        b = 16'h4200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_div_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check("no_spurious_result", 32'(spurious), 32'd0);
        do_txn(16'h4400, 16'h4000, 16'h4000, 5'h00);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
